// File: rtl/mem_arb_types.sv
// mem_arb_types: shared client and per-client FSM state enums for the cacheline arbiter
package mem_arb_types;
  typedef enum logic {CLIENT_I = 1'b0, CLIENT_D = 1'b1} client_e;
  typedef enum logic {IDLE = 1'b0, WAIT_R = 1'b1} st_e;
endpackage

// File: rtl/cacheline_itf.sv
// cacheline_itf: request bundle (addr/read/write/wdata/ready) plus read-response bundle (raddr/rdata/rvalid)
interface cacheline_itf #(parameter int ADDR_W = 32, parameter int LINE_W = 256);
  logic [ADDR_W-1:0] addr, raddr;
  logic [LINE_W-1:0] wdata, rdata;
  logic read, write, ready, rvalid;
  modport master(output addr, read, write, wdata, input ready, raddr, rdata, rvalid);
  modport slave(input addr, read, write, wdata, output ready, raddr, rdata, rvalid);
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin grant (req[0]=icache, req[1]=dcache); rr_last moves only on accept
module rr_arbiter2
  import mem_arb_types::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);
  client_e rr_last_q, rr_last_d, win;
  always_comb begin
    win = (req == 2'b11) ? (rr_last_q == CLIENT_D ? CLIENT_I : CLIENT_D) : (req[0] ? CLIENT_I : CLIENT_D);
    gnt = (|req) ? (win == CLIENT_I ? 2'b01 : 2'b10) : 2'b00;
    rr_last_d = (accept && |req) ? win : rr_last_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) rr_last_q <= CLIENT_D;
    else rr_last_q <= rr_last_d;
endmodule

// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter: icache/dcache slaves share one mem master; responses routed by pending address; err flags unmatched rvalid
module cacheline_arbiter
  import mem_arb_types::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
) (
  input  logic        clk,
  input  logic        rst,
  cacheline_itf.slave icache,
  cacheline_itf.slave dcache,
  cacheline_itf.master mem,
  output logic        err
);
  st_e st_q [2];
  st_e st_d [2];
  logic [ADDR_W-1:0] pend_q [2];
  logic [ADDR_W-1:0] pend_d [2];
  client_e older_q, older_d;
  logic err_q, err_d, rv;
  logic [1:0] req, gnt, match, dlv, acc_rd;
  rr_arbiter2 u_rr (.clk(clk), .rst(rst), .req(req), .accept(mem.ready), .gnt(gnt));
  always_comb begin
    req[0] = !rst && st_q[0] == IDLE && icache.read;
    req[1] = !rst && st_q[1] == IDLE && (dcache.read || dcache.write);
    mem.read = (gnt[0] & icache.read) | (gnt[1] & dcache.read);
    mem.write = gnt[1] & dcache.write;
    mem.addr = gnt[0] ? icache.addr : gnt[1] ? dcache.addr : '0;
    mem.wdata = gnt[1] ? dcache.wdata : '0;
    icache.ready = mem.ready & gnt[0];
    dcache.ready = mem.ready & gnt[1];
    rv = mem.rvalid & !rst;
    match[0] = rv && st_q[0] == WAIT_R && pend_q[0] == mem.raddr;
    match[1] = rv && st_q[1] == WAIT_R && pend_q[1] == mem.raddr;
    dlv[0] = match[0] & (!match[1] | older_q == CLIENT_I);
    dlv[1] = match[1] & (!match[0] | older_q == CLIENT_D);
    icache.rvalid = dlv[0];
    icache.rdata = dlv[0] ? mem.rdata : '0;
    icache.raddr = dlv[0] ? mem.raddr : '0;
    dcache.rvalid = dlv[1];
    dcache.rdata = dlv[1] ? mem.rdata : '0;
    dcache.raddr = dlv[1] ? mem.raddr : '0;
    acc_rd[0] = icache.ready & icache.read;
    acc_rd[1] = dcache.ready & dcache.read;
    for (int c = 0; c < 2; c++) begin
      st_d[c] = acc_rd[c] ? WAIT_R : dlv[c] ? IDLE : st_q[c];
      pend_d[c] = acc_rd[c] ? mem.addr : pend_q[c];
    end
    older_d = acc_rd[0] ? (st_q[1] == WAIT_R ? CLIENT_D : CLIENT_I) :
              acc_rd[1] ? (st_q[0] == WAIT_R ? CLIENT_I : CLIENT_D) : older_q;
    err_d = err_q | (rv & ~|match);
    err = err_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        st_q[c] <= IDLE;
        pend_q[c] <= '0;
      end
      older_q <= CLIENT_I;
      err_q <= 1'b0;
    end else begin
      for (int c = 0; c < 2; c++) begin
        st_q[c] <= st_d[c];
        pend_q[c] <= pend_d[c];
      end
      older_q <= older_d;
      err_q <= err_d;
    end
endmodule

// File: doc/cacheline_arbiter.md
CACHELINE_ARBITER -- requirements
Module: cacheline_arbiter

Interface
REQ-001 Parameters (name, default, meaning) SHALL be ADDR_W, 32, byte address width; LINE_W, 256, cacheline width.
REQ-002 Clocking SHALL be: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 icache  cacheline_itf.slave  bundle  instruction-cache requester; read-only, its write SHALL be ignored.
REQ-006 dcache  cacheline_itf.slave  bundle  data-cache requester; read and write-back.
REQ-007 mem  cacheline_itf.master  bundle  single shared downstream memory port.
REQ-008 err  output  1  sticky flag; unmatched read response seen.
REQ-009 Every bundle SHALL carry addr[ADDR_W], read, write, wdata[LINE_W], ready, raddr[ADDR_W], rdata[LINE_W], rvalid; a request is accepted in the cycle where (read|write) and ready are both high.

Function
REQ-010 Each client SHALL have a two-state FSM: IDLE, WAIT_R; IDLE->WAIT_R on accepted read, WAIT_R->IDLE on its delivered rvalid.
REQ-011 A client SHALL be eligible when in IDLE with read or write high; WAIT_R clients are never eligible.
REQ-012 Grant SHALL be combinational among eligible clients; tie-break goes to the client not granted last (rr_last register, updated only on acceptance).
REQ-013 mem.addr/read/write/wdata SHALL mirror the granted client; with no grant, read=write=0 and addr/wdata=0.
REQ-014 client.ready SHALL equal mem.ready AND (client granted); ungranted client ready=0.
REQ-015 Accepted read SHALL latch pend_addr[client]=addr; writes complete at acceptance, no state change.
REQ-016 If the other client is already in WAIT_R at a read acceptance, the new read SHALL be marked younger (older bit register).
REQ-017 On mem.rvalid, raddr SHALL be compared to pend_addr of WAIT_R clients; match delivers rvalid, rdata, raddr to that client for exactly that cycle.
REQ-018 If both clients match the same raddr, delivery SHALL go to the older; the younger stays in WAIT_R for the next response.
REQ-019 Unmatched rvalid SHALL be dropped and set err=1 until reset.
REQ-020 Eligibility SHALL use registered FSM state: a client receiving rvalid in cycle N may be granted no earlier than cycle N+1.
REQ-021 Acceptance and rvalid in the same cycle SHALL both be processed; rvalid matching uses pre-cycle state.
REQ-022 Latency SHALL be zero cycles request path (combinational), zero cycles response path.

Reset
REQ-023 On rst: both FSMs IDLE, pend_addr=0, older=0, rr_last=dcache (icache wins first tie), err=0.
REQ-024 During rst all client ready/rvalid and mem read/write SHALL be 0; reset mid-transaction SHALL abandon outstanding reads, later responses raising err.

Structure
REQ-025 Shared package mem_arb_types SHALL hold the client enum (CLIENT_I, CLIENT_D) and FSM state enum.
REQ-026 One sub-module, rr_arbiter2 (two-requester round-robin grant with rr_last register), SHALL be instantiated; the rest is flat.

Verification
REQ-027 Only icache reads 0x0000_1000, mem.ready=1 -> icache.ready=1 same cycle; rvalid raddr=0x1000 later -> icache.rvalid=1, dcache.rvalid=0.
REQ-028 Both read simultaneously after reset, ready=1 -> icache granted first, dcache granted next cycle; rr_last=icache after first acceptance.
REQ-029 dcache write 0x2000 with wdata=all 0xA5 then read 0x3000 -> mem sees write then read; dcache never enters WAIT_R for the write.
REQ-030 Both read 0x4000 (icache first) -> two rvalids raddr=0x4000 -> first to icache, second to dcache.
REQ-031 rvalid raddr=0x9000 with nothing pending -> no client rvalid, err=1 held until rst.
REQ-032 Assert rst while icache in WAIT_R -> all outputs 0 immediately; post-reset response raddr match -> err=1.
